// File: rtl/lsu_dmem_ctrl.sv
//------------------------------------------------------------------------------
// lsu_dmem_ctrl
//
// Memory-side responder for the execute -> LSU interface. A load or store
// offered by execute is checked for alignment. An aligned access is launched
// on a req/ack data-memory port, and execute is stalled until the access
// completes. Load data is shifted into place and sign- or zero-extended before
// it is returned to writeback. A misaligned access, or an access that gets no
// ack within TIMEOUT_CYCLES, raises a one-cycle fault pulse that carries the
// faulting effective address.
//
// Ports
//   clk, rst            core clock; synchronous active-high reset
//   exe_valid_i         execute presents an instruction this cycle
//   alu_result_i        effective address
//   rs2_data_i          store data
//   ld_ops_i            1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU (0, 6, 7 = no load)
//   st_ops_i            1 SB, 2 SH, 3 SW (0 = no store)
//   rd_addr_i           load destination register
//   flush_i             pipeline flush
//   lsu_stall_o         hold execute and earlier stages
//   dmem_req_o          memory request, held until ack
//   dmem_we_o           1 = write
//   dmem_addr_o         word-aligned address
//   dmem_wdata_o        lane-replicated store data
//   dmem_sel_o          byte enables
//   dmem_ack_i          memory completes the access
//   dmem_rdata_i        read word (valid with ack)
//   ld_valid_o          one-cycle pulse: load result valid
//   ld_data_o           extended load result
//   ld_rd_addr_o        destination register of ld_data_o
//   misalign_ld_o       one-cycle pulse: misaligned load
//   misalign_st_o       one-cycle pulse: misaligned store
//   bus_err_o           one-cycle pulse: ack timeout
//   fault_addr_o        faulting effective address (valid with any fault pulse)
//------------------------------------------------------------------------------
module lsu_dmem_ctrl #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exe_valid_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [2:0]      ld_ops_i,
    input  logic [1:0]      st_ops_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            lsu_stall_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [3:0]      dmem_sel_o,
    input  logic            dmem_ack_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            ld_valid_o,
    output logic [XLEN-1:0] ld_data_o,
    output logic [4:0]      ld_rd_addr_o,
    output logic            misalign_ld_o,
    output logic            misalign_st_o,
    output logic            bus_err_o,
    output logic [XLEN-1:0] fault_addr_o
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LH   = 3'd2,
        LD_LW   = 3'd3,
        LD_LBU  = 3'd4,
        LD_LHU  = 3'd5
    } ld_op_t;

    localparam bit HAS_TIMEOUT = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W       = HAS_TIMEOUT ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Value held in the counter during the last WAIT cycle before timeout.
    localparam logic [CNT_W-1:0] CNT_LAST = HAS_TIMEOUT ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              flushed_q;
    logic [XLEN-1:0]   addr_q;
    logic [3:0]        sel_q;
    logic [XLEN-1:0]   wdata_q;
    logic              we_q;
    ld_op_t            ld_op_q;
    logic [4:0]        rd_q;

    // Request decode
    logic              is_store;
    logic              is_load;
    logic              is_half;
    logic              is_word;
    logic              misaligned;
    logic              accept;
    logic [3:0]        sel_d;
    logic [XLEN-1:0]   wdata_d;
    logic              timeout_hit;
    logic [XLEN-1:0]   ld_shift;
    logic [XLEN-1:0]   ld_ext;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        is_store   = (st_ops_i != 2'd0);
        // A store wins when execute sets both a load and a store op.
        is_load    = !is_store && (ld_ops_i >= 3'd1) && (ld_ops_i <= 3'd5);
        is_half    = is_store ? (st_ops_i == 2'd2)
                              : ((ld_ops_i == LD_LH) || (ld_ops_i == LD_LHU));
        is_word    = is_store ? (st_ops_i == 2'd3) : (ld_ops_i == LD_LW);
        misaligned = (is_half && alu_result_i[0]) || (is_word && (alu_result_i[1:0] != 2'b00));
        accept     = (state_q == S_IDLE) && exe_valid_i && !flush_i && (is_store || is_load);

        if (is_word) begin
            sel_d = 4'hF;
        end else if (is_half) begin
            sel_d = 4'b0011 << alu_result_i[1:0];
        end else begin
            sel_d = 4'b0001 << alu_result_i[1:0];
        end

        wdata_d = '0;
        if (is_store) begin
            case (st_ops_i)
                2'd1:    wdata_d = {(XLEN/8){rs2_data_i[7:0]}};
                2'd2:    wdata_d = {(XLEN/16){rs2_data_i[15:0]}};
                default: wdata_d = rs2_data_i;
            endcase
        end
    end

    assign timeout_hit = HAS_TIMEOUT && (cnt_q == CNT_LAST);

    // Next state and stall
    always_comb begin
        state_d     = state_q;
        lsu_stall_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A misaligned access never touches memory, so it never stalls.
                if (accept && !misaligned) begin
                    lsu_stall_o = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                lsu_stall_o = !dmem_ack_i;
                if (dmem_ack_i || timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            lsu_stall_o = 1'b0;
        end
    end

    // Load alignment and extension of the returned word.
    always_comb begin
        ld_shift = dmem_rdata_i >> {addr_q[1:0], 3'b000};
        case (ld_op_q)
            LD_LB:   ld_ext = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            LD_LH:   ld_ext = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            LD_LBU:  ld_ext = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
            LD_LHU:  ld_ext = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    // NOTE: state and output registers use non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are reset too, not just the FSM,
            // because every output must read 0 right after reset.
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            flushed_q     <= 1'b0;
            addr_q        <= '0;
            sel_q         <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            ld_op_q       <= LD_NONE;
            rd_q          <= '0;
            ld_valid_o    <= 1'b0;
            ld_data_o     <= '0;
            ld_rd_addr_o  <= '0;
            misalign_ld_o <= 1'b0;
            misalign_st_o <= 1'b0;
            bus_err_o     <= 1'b0;
            fault_addr_o  <= '0;
        end else begin
            state_q       <= state_d;
            ld_valid_o    <= 1'b0;
            misalign_ld_o <= 1'b0;
            misalign_st_o <= 1'b0;
            bus_err_o     <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    cnt_q     <= '0;
                    flushed_q <= 1'b0;
                    if (accept) begin
                        if (misaligned) begin
                            misalign_st_o <= is_store;
                            misalign_ld_o <= !is_store;
                            fault_addr_o  <= alu_result_i;
                        end else begin
                            addr_q  <= alu_result_i;
                            sel_q   <= sel_d;
                            wdata_q <= wdata_d;
                            we_q    <= is_store;
                            ld_op_q <= is_store ? LD_NONE : ld_op_t'(ld_ops_i);
                            rd_q    <= rd_addr_i;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_ack_i) begin
                        cnt_q     <= '0;
                        flushed_q <= 1'b0;
                        // A flush seen at any point of the access, including
                        // the ack cycle itself, discards the load result.
                        if (!we_q && !(flushed_q || flush_i)) begin
                            ld_valid_o   <= 1'b1;
                            ld_data_o    <= ld_ext;
                            ld_rd_addr_o <= rd_q;
                        end
                    end else if (timeout_hit) begin
                        cnt_q        <= '0;
                        flushed_q    <= 1'b0;
                        bus_err_o    <= 1'b1;
                        fault_addr_o <= addr_q;
                    end else begin
                        if (HAS_TIMEOUT) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        flushed_q <= flushed_q || flush_i;
                    end
                end
                default: begin
                    cnt_q     <= '0;
                    flushed_q <= 1'b0;
                end
            endcase
        end
    end

    // The memory port is driven only while a request is outstanding.
    always_comb begin
        dmem_req_o   = (state_q == S_WAIT);
        dmem_we_o    = dmem_req_o && we_q;
        dmem_addr_o  = dmem_req_o ? {addr_q[XLEN-1:2], 2'b00} : '0;
        dmem_sel_o   = dmem_req_o ? sel_q : 4'h0;
        dmem_wdata_o = dmem_req_o ? wdata_q : '0;
    end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
//------------------------------------------------------------------------------
// tb_lsu_dmem_ctrl
//
// Directed bench for lsu_dmem_ctrl with TIMEOUT_CYCLES = 4. A transaction-level
// model derives the expected memory transaction, stall and result pulses from
// access size and byte offset; a compare process checks the DUT against it at
// every falling edge. Directed sequences add hand-computed literal checks.
// Inputs change 1 time unit after the rising edge.
//------------------------------------------------------------------------------
module tb_lsu_dmem_ctrl;

    localparam int XLEN = 32;
    localparam int TO   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            exe_valid_i = 1'b0;
    logic [31:0]     alu_result_i = '0;
    logic [31:0]     rs2_data_i = '0;
    logic [2:0]      ld_ops_i = '0;
    logic [1:0]      st_ops_i = '0;
    logic [4:0]      rd_addr_i = '0;
    logic            flush_i = 1'b0;
    logic            dmem_ack_i = 1'b0;
    logic [31:0]     dmem_rdata_i = '0;
    logic            lsu_stall_o;
    logic            dmem_req_o;
    logic            dmem_we_o;
    logic [31:0]     dmem_addr_o;
    logic [31:0]     dmem_wdata_o;
    logic [3:0]      dmem_sel_o;
    logic            ld_valid_o;
    logic [31:0]     ld_data_o;
    logic [4:0]      ld_rd_addr_o;
    logic            misalign_ld_o;
    logic            misalign_st_o;
    logic            bus_err_o;
    logic [31:0]     fault_addr_o;

    int n_checks   = 0;
    int n_errors   = 0;
    int req_cycles = 0;

    lsu_dmem_ctrl #(
        .XLEN           (XLEN),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .exe_valid_i   (exe_valid_i),
        .alu_result_i  (alu_result_i),
        .rs2_data_i    (rs2_data_i),
        .ld_ops_i      (ld_ops_i),
        .st_ops_i      (st_ops_i),
        .rd_addr_i     (rd_addr_i),
        .flush_i       (flush_i),
        .lsu_stall_o   (lsu_stall_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_sel_o    (dmem_sel_o),
        .dmem_ack_i    (dmem_ack_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .ld_valid_o    (ld_valid_o),
        .ld_data_o     (ld_data_o),
        .ld_rd_addr_o  (ld_rd_addr_o),
        .misalign_ld_o (misalign_ld_o),
        .misalign_st_o (misalign_st_o),
        .bus_err_o     (bus_err_o),
        .fault_addr_o  (fault_addr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    //--------------------------------------------------------------------------
    // Reference model: access size in bytes drives every rule.
    //--------------------------------------------------------------------------
    function automatic int op_size(input logic [2:0] ld, input logic [1:0] st);
        if (st != 2'd0) return 1 << (int'(st) - 1);
        case (ld)
            3'd1, 3'd4: return 1;
            3'd2, 3'd5: return 2;
            3'd3:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [3:0] exp_sel(input int sz, input logic [1:0] off);
        int m;
        m = ((1 << sz) - 1) << off;
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] d);
        case (sz)
            1:       return {24'd0, d[7:0]} * 32'h0101_0101;
            2:       return {16'd0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] rdata);
        longint v;
        int     bits;
        bits = 8 * op_size(op, 2'd0);
        v = longint'({32'd0, rdata});
        v = (v >> (8 * int'(off))) & ((longint'(1) << bits) - 1);
        if ((op == 3'd1 || op == 3'd2) && v >= (longint'(1) << (bits - 1)))
            v = v - (longint'(1) << bits);
        return v[31:0];
    endfunction

    bit          m_busy = 1'b0;
    int          m_waits = 0;
    bit          m_flushed = 1'b0;
    logic [31:0] m_eff = '0;
    bit          m_we = 1'b0;
    logic [2:0]  m_op = '0;
    logic [4:0]  m_rd = '0;
    logic [3:0]  m_sel = '0;
    logic [31:0] m_wdata = '0;
    bit          m_ldv = 1'b0;
    bit          m_mis_ld = 1'b0;
    bit          m_mis_st = 1'b0;
    bit          m_berr = 1'b0;
    logic [31:0] m_ld_data = '0;
    logic [4:0]  m_ld_rd = '0;
    logic [31:0] m_fault = '0;

    always @(posedge clk) begin : model
        int sz;
        bit fl;
        m_ldv    <= 1'b0;
        m_mis_ld <= 1'b0;
        m_mis_st <= 1'b0;
        m_berr   <= 1'b0;
        if (rst) begin
            m_busy    <= 1'b0;
            m_waits   <= 0;
            m_flushed <= 1'b0;
        end else if (m_busy) begin
            fl = m_flushed || flush_i;
            if (dmem_ack_i) begin
                m_busy    <= 1'b0;
                m_flushed <= 1'b0;
                if (!m_we && !fl) begin
                    m_ldv     <= 1'b1;
                    m_ld_data <= load_value(m_op, m_eff[1:0], dmem_rdata_i);
                    m_ld_rd   <= m_rd;
                end
            end else if (TO > 0 && m_waits + 1 == TO) begin
                m_busy    <= 1'b0;
                m_flushed <= 1'b0;
                m_berr    <= 1'b1;
                m_fault   <= m_eff;
            end else begin
                m_waits   <= m_waits + 1;
                m_flushed <= fl;
            end
        end else begin
            sz = op_size(ld_ops_i, st_ops_i);
            if (exe_valid_i && !flush_i && sz > 0) begin
                if (int'(alu_result_i[1:0]) % sz != 0) begin
                    m_mis_st <= (st_ops_i != 2'd0);
                    m_mis_ld <= (st_ops_i == 2'd0);
                    m_fault  <= alu_result_i;
                end else begin
                    m_busy    <= 1'b1;
                    m_waits   <= 0;
                    m_flushed <= 1'b0;
                    m_eff     <= alu_result_i;
                    m_we      <= (st_ops_i != 2'd0);
                    m_op      <= ld_ops_i;
                    m_rd      <= rd_addr_i;
                    m_sel     <= exp_sel(sz, alu_result_i[1:0]);
                    m_wdata   <= (st_ops_i != 2'd0) ? exp_wdata(sz, rs2_data_i) : 32'd0;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        bit exp_stall;
        int sz;
        if (!rst) begin
            sz = op_size(ld_ops_i, st_ops_i);
            if (m_busy)
                exp_stall = !dmem_ack_i;
            else
                exp_stall = exe_valid_i && !flush_i && sz > 0 && (int'(alu_result_i[1:0]) % sz == 0);
            check("req", 32'(dmem_req_o), 32'(m_busy));
            check("stall", 32'(lsu_stall_o), 32'(exp_stall));
            check("ld_valid", 32'(ld_valid_o), 32'(m_ldv));
            check("misalign_ld", 32'(misalign_ld_o), 32'(m_mis_ld));
            check("misalign_st", 32'(misalign_st_o), 32'(m_mis_st));
            check("bus_err", 32'(bus_err_o), 32'(m_berr));
            if (m_busy) begin
                check("dmem_addr", dmem_addr_o, {m_eff[31:2], 2'b00});
                check("dmem_we", 32'(dmem_we_o), 32'(m_we));
                check("dmem_sel", 32'(dmem_sel_o), 32'(m_sel));
                check("dmem_wdata", dmem_wdata_o, m_wdata);
            end
            if (m_ldv) begin
                check("ld_data", ld_data_o, m_ld_data);
                check("ld_rd", 32'(ld_rd_addr_o), 32'(m_ld_rd));
            end
            if (m_mis_ld || m_mis_st || m_berr)
                check("fault_addr", fault_addr_o, m_fault);
            if (dmem_req_o)
                req_cycles++;
        end
    end

    //--------------------------------------------------------------------------
    // Stimulus helpers
    //--------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] rd);
        exe_valid_i  = 1'b1;
        ld_ops_i     = ld;
        st_ops_i     = st;
        alu_result_i = addr;
        rs2_data_i   = data;
        rd_addr_i    = rd;
    endtask

    task automatic idle_inputs();
        exe_valid_i  = 1'b0;
        ld_ops_i     = '0;
        st_ops_i     = '0;
        alu_result_i = '0;
        rs2_data_i   = '0;
        rd_addr_i    = '0;
    endtask

    // Called at the start of the first WAIT cycle; ack lands in WAIT cycle
    // number 'delay'. Returns at the start of the cycle after the ack.
    task automatic respond(input int delay, input logic [31:0] rdata);
        for (int i = 1; i < delay; i++) step();
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rdata;
        #1 check("stall in ack cycle", 32'(lsu_stall_o), 32'd0);
        step();
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = '0;
    endtask

    //--------------------------------------------------------------------------
    // Directed sequence
    //--------------------------------------------------------------------------
    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset req", 32'(dmem_req_o), 32'd0);
        check("reset stall", 32'(lsu_stall_o), 32'd0);
        check("reset ld_valid", 32'(ld_valid_o), 32'd0);
        check("reset ld_data", ld_data_o, 32'd0);
        check("reset faults", {29'd0, misalign_ld_o, misalign_st_o, bus_err_o}, 32'd0);
        check("reset fault_addr", fault_addr_o, 32'd0);
        check("reset dmem_sel", 32'(dmem_sel_o), 32'd0);

        // SW 0x1000, ack in the third WAIT cycle.
        step();
        issue(3'd0, 2'd3, 32'h0000_1000, 32'hDEAD_BEEF, 5'd0);
        #1 check("sw stall in accept", 32'(lsu_stall_o), 32'd1);
        step();
        idle_inputs();
        req_cycles = 0;
        check("sw addr", dmem_addr_o, 32'h0000_1000);
        check("sw we", 32'(dmem_we_o), 32'd1);
        check("sw sel", 32'(dmem_sel_o), 32'h0000_000F);
        check("sw wdata", dmem_wdata_o, 32'hDEAD_BEEF);
        respond(3, 32'd0);
        check("sw req cycles", 32'(req_cycles), 32'd3);
        check("sw req after ack", 32'(dmem_req_o), 32'd0);

        // LB 0x2003, ack in the first WAIT cycle.
        step();
        issue(3'd1, 2'd0, 32'h0000_2003, 32'd0, 5'd5);
        step();
        idle_inputs();
        check("lb sel", 32'(dmem_sel_o), 32'h0000_0008);
        respond(1, 32'h8011_2233);
        check("lb valid", 32'(ld_valid_o), 32'd1);
        check("lb data", ld_data_o, 32'hFFFF_FF80);
        check("lb rd", 32'(ld_rd_addr_o), 32'd5);

        // LHU 0x2002.
        step();
        issue(3'd5, 2'd0, 32'h0000_2002, 32'd0, 5'd7);
        step();
        idle_inputs();
        respond(2, 32'h8001_ABCD);
        check("lhu data", ld_data_o, 32'h0000_8001);

        // LH 0x2002, same word: sign extension.
        step();
        issue(3'd2, 2'd0, 32'h0000_2002, 32'd0, 5'd8);
        step();
        idle_inputs();
        respond(1, 32'h8001_ABCD);
        check("lh data", ld_data_o, 32'hFFFF_8001);

        // SB 0x11.
        step();
        issue(3'd0, 2'd1, 32'h0000_0011, 32'h1234_565A, 5'd0);
        step();
        idle_inputs();
        check("sb sel", 32'(dmem_sel_o), 32'h0000_0002);
        check("sb wdata", dmem_wdata_o, 32'h5A5A_5A5A);
        check("sb addr", dmem_addr_o, 32'h0000_0010);
        respond(1, 32'd0);

        // Misaligned LW 0x3002.
        step();
        issue(3'd3, 2'd0, 32'h0000_3002, 32'd0, 5'd1);
        #1 check("lw misalign no stall", 32'(lsu_stall_o), 32'd0);
        step();
        idle_inputs();
        check("lw misalign pulse", 32'(misalign_ld_o), 32'd1);
        check("lw misalign fault_addr", fault_addr_o, 32'h0000_3002);
        check("lw misalign no req", 32'(dmem_req_o), 32'd0);

        // Misaligned SH 0x5001.
        step();
        issue(3'd0, 2'd2, 32'h0000_5001, 32'h0000_BEEF, 5'd0);
        step();
        idle_inputs();
        check("sh misalign pulse", 32'(misalign_st_o), 32'd1);
        check("sh misalign fault_addr", fault_addr_o, 32'h0000_5001);

        // Load with no ack: times out after TO WAIT cycles.
        step();
        issue(3'd3, 2'd0, 32'h0000_4000, 32'd0, 5'd3);
        step();
        idle_inputs();
        req_cycles = 0;
        repeat (TO) step();
        check("timeout req cycles", 32'(req_cycles), 32'd4);
        check("timeout bus_err", 32'(bus_err_o), 32'd1);
        check("timeout fault_addr", fault_addr_o, 32'h0000_4000);
        check("timeout req dropped", 32'(dmem_req_o), 32'd0);

        // Load flushed in its first WAIT cycle: access completes, no result.
        step();
        issue(3'd2, 2'd0, 32'h0000_2000, 32'd0, 5'd9);
        step();
        idle_inputs();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        respond(2, 32'h0000_F00D);
        check("flushed load no valid", 32'(ld_valid_o), 32'd0);

        // Flush in IDLE blocks acceptance.
        step();
        issue(3'd3, 2'd0, 32'h0000_6000, 32'd0, 5'd2);
        flush_i = 1'b1;
        #1 check("idle flush no stall", 32'(lsu_stall_o), 32'd0);
        step();
        idle_inputs();
        flush_i = 1'b0;
        check("idle flush no req", 32'(dmem_req_o), 32'd0);

        // Back-to-back: execute holds LBU valid; re-accepted only after ack.
        step();
        issue(3'd4, 2'd0, 32'h0000_2001, 32'd0, 5'd4);
        step();
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h8001_ABCD;
        #1 check("b2b stall in ack cycle", 32'(lsu_stall_o), 32'd0);
        step();
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = '0;
        #1 check("b2b reaccept stall", 32'(lsu_stall_o), 32'd1);
        check("b2b no req after ack", 32'(dmem_req_o), 32'd0);
        check("b2b first data", ld_data_o, 32'h0000_00AB);
        step();
        idle_inputs();
        respond(1, 32'h0000_FF00);
        check("b2b second data", ld_data_o, 32'h0000_00FF);

        // Load and store both set: treated as SB at offset 3.
        step();
        issue(3'd3, 2'd1, 32'h0000_2003, 32'h0000_00C3, 5'd6);
        step();
        idle_inputs();
        check("ld+st we", 32'(dmem_we_o), 32'd1);
        check("ld+st sel", 32'(dmem_sel_o), 32'h0000_0008);
        check("ld+st wdata", dmem_wdata_o, 32'hC3C3_C3C3);
        respond(1, 32'd0);
        check("ld+st no load result", 32'(ld_valid_o), 32'd0);

        // Ack while idle is ignored.
        step();
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 32'h1111_1111;
        step();
        step();
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = '0;
        check("idle ack no valid", 32'(ld_valid_o), 32'd0);

        // Reset in the middle of WAIT; a late ack follows.
        step();
        issue(3'd0, 2'd3, 32'h0000_7000, 32'h0000_0001, 5'd0);
        step();
        idle_inputs();
        step();
        rst = 1'b1;
        step();
        rst        = 1'b0;
        dmem_ack_i = 1'b1;
        check("rst req", 32'(dmem_req_o), 32'd0);
        check("rst we", 32'(dmem_we_o), 32'd0);
        check("rst addr", dmem_addr_o, 32'd0);
        check("rst wdata", dmem_wdata_o, 32'd0);
        check("rst stall", 32'(lsu_stall_o), 32'd0);
        check("rst pulses", {28'd0, ld_valid_o, misalign_ld_o, misalign_st_o, bus_err_o}, 32'd0);
        step();
        dmem_ack_i = 1'b0;
        check("late ack ignored", 32'(ld_valid_o), 32'd0);
        check("late ack no req", 32'(dmem_req_o), 32'd0);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
